// File: rtl/quad_enc_ctrl_pkg.sv
// rtl/quad_enc_ctrl_pkg.sv - QEncPkg: phase/sub-step types, Gray phase constants and phase_of() decode
package QEncPkg;

   typedef logic [1:0]        phase_t;
   typedef logic signed [3:0] sub_t;

   localparam phase_t PH_00      = 2'd0;
   localparam phase_t PH_10      = 2'd1;
   localparam phase_t PH_11      = 2'd2;
   localparam phase_t PH_01      = 2'd3;
   localparam sub_t   SUB_DETENT = 4'sd4;

   // Map the filtered contact pair (a,b) onto the Gray-ordered phase index; CW (A leads) counts up.
   function automatic phase_t phase_of(input logic a, input logic b);
      phase_t ph;
      case ({a, b})
         2'b00:   ph = PH_00;
         2'b10:   ph = PH_10;
         2'b11:   ph = PH_11;
         default: ph = PH_01;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/quad_enc_ctrl_glitch_filter.sv
// rtl/quad_enc_ctrl_glitch_filter.sv - glitch_filter: 2-FF synchronizer plus FILT_CYC stability counter
module glitch_filter #(
   parameter int FILT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int                CNT_W    = $clog2(FILT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer for the asynchronous contact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed from dout for FILT_CYC consecutive cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (sync2 == dout) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         dout <= sync2;
         cnt  <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/quad_enc_ctrl.sv
// rtl/quad_enc_ctrl.sv - quadrature encoder front end: filter, Gray decode, detent steps, position (QENC_SAT_EN saturates pos)
module quad_enc_ctrl
   import QEncPkg::*;
#(
   parameter int FILT_CYC = 16,
   parameter int POS_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a,
   input  logic                    b,
   input  logic                    clr,
   input  logic                    load,
   input  logic signed [POS_W-1:0] load_val,
   output logic signed [POS_W-1:0] pos,
   output logic                    step_cw,
   output logic                    step_ccw,
   output logic                    err
);

   localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
`ifdef QENC_SAT_EN
   localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
`endif

   logic                    fa;
   logic                    fb;
   phase_t                  ph_q;
   phase_t                  ph_new;
   phase_t                  d;
   sub_t                    sub;
   sub_t                    sub_n;
   logic                    cw_n;
   logic                    ccw_n;
   logic                    err_n;
   logic signed [POS_W-1:0] pos_n;

   glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt_a (
      .clk  (clk),
      .rst  (rst),
      .din  (a),
      .dout (fa)
   );

   glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt_b (
      .clk  (clk),
      .rst  (rst),
      .din  (b),
      .dout (fb)
   );

   // Phase delta drives sub-step counting; a detent completes on return to 00 with sub at +/-4.
   always_comb begin
      ph_new = phase_of(fa, fb);
      d      = ph_new - ph_q;
      sub_n  = sub;
      cw_n   = 1'b0;
      ccw_n  = 1'b0;
      err_n  = 1'b0;
      pos_n  = pos;
      case (d)
         2'd1:    if (sub != SUB_DETENT)  sub_n = sub + 4'sd1;
         2'd3:    if (sub != -SUB_DETENT) sub_n = sub - 4'sd1;
         2'd2:    err_n = 1'b1;
         default: ;
      endcase
      if (ph_new == PH_00) begin
         cw_n  = (sub_n == SUB_DETENT);
         ccw_n = (sub_n == -SUB_DETENT);
         sub_n = '0;
      end
      if (clr) begin
         pos_n = '0;
         sub_n = '0;
      end else if (load) begin
         pos_n = load_val;
      end else if (cw_n) begin
`ifdef QENC_SAT_EN
         if (pos != POS_MAX) pos_n = pos + POS_ONE;
`else
         pos_n = pos + POS_ONE;
`endif
      end else if (ccw_n) begin
`ifdef QENC_SAT_EN
         if (pos != POS_MIN) pos_n = pos - POS_ONE;
`else
         pos_n = pos - POS_ONE;
`endif
      end
   end

   // Register phase history, sub-step count, position and the one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q     <= PH_00;
         sub      <= '0;
         pos      <= '0;
         step_cw  <= 1'b0;
         step_ccw <= 1'b0;
         err      <= 1'b0;
      end else begin
         ph_q     <= ph_new;
         sub      <= sub_n;
         pos      <= pos_n;
         step_cw  <= cw_n;
         step_ccw <= ccw_n;
         err      <= err_n;
      end
   end

endmodule

// File: tb/tb_quad_enc_ctrl.sv
// tb/tb_quad_enc_ctrl.sv - directed scoreboard bench for quad_enc_ctrl (FILT_CYC=4, POS_W=8)
module tb_quad_enc_ctrl;

   localparam int FILT_CYC = 4;
   localparam int POS_W    = 8;
   localparam int Q        = 20;
   localparam int LAT      = FILT_CYC + 3;

   typedef struct {
      logic [2:0] flags;
      logic [7:0] pos;
      int         cyc;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;

   logic       clk = 1'b0;
   logic       rst;
   logic       a;
   logic       b;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] pos;
   logic       step_cw;
   logic       step_ccw;
   logic       err;

   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] pos_model;

   quad_enc_ctrl #(.FILT_CYC(FILT_CYC), .POS_W(POS_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .pos      (pos),
      .step_cw  (step_cw),
      .step_ccw (step_ccw),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] step_model(input logic [7:0] p, input bit up);
`ifdef QENC_SAT_EN
      if (up) return (p == 8'h7F) ? p : p + 8'd1;
      return (p == 8'h80) ? p : p - 8'd1;
`else
      return up ? p + 8'd1 : p - 8'd1;
`endif
   endfunction

   // Every pulse must match the oldest outstanding expectation: kind, position and edge.
   always @(negedge clk) begin
      if (!rst && (step_cw || step_ccw || err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {29'd0, err, step_ccw, step_cw}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_kind", {29'd0, err, step_ccw, step_cw}, {29'd0, mon_e.flags});
            check("pulse_pos", {24'd0, pos}, {24'd0, mon_e.pos});
            check("pulse_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic na, input logic nb);
      a = na;
      b = nb;
      hold(Q);
   endtask

   task automatic expect_ev(input logic [2:0] f, input logic [7:0] p);
      ev_t e;
      e.flags = f;
      e.pos   = p;
      e.cyc   = cyc + LAT;
      exp_q.push_back(e);
   endtask

   task automatic cw_detent();
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      pos_model = step_model(pos_model, 1'b1);
      expect_ev(3'b001, pos_model);
      drive(1'b0, 1'b0);
   endtask

   task automatic ccw_detent();
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
      pos_model = step_model(pos_model, 1'b0);
      expect_ev(3'b010, pos_model);
      drive(1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; a = 1'b0; b = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0;
      pos_model = 8'd0;
      hold(3);
      check("reset_pos", {24'd0, pos}, 32'd0);
      check("reset_pulses", {29'd0, err, step_ccw, step_cw}, 32'd0);
      rst = 1'b0;
      hold(Q);

      repeat (3) cw_detent();
      check("t1_pos", {24'd0, pos}, 32'd3);
      check("t1_pending", exp_q.size(), 32'd0);

      repeat (5) ccw_detent();
      check("t2_pos", {24'd0, pos}, 32'hFE);
      check("t2_pending", exp_q.size(), 32'd0);

      repeat (30) begin
         a = 1'b1; hold(2);
         a = 1'b0; hold(3);
      end
      hold(Q);
      check("t3_bounce_pos", {24'd0, pos}, {24'd0, pos_model});
      a = 1'b1; hold(30);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      pos_model = step_model(pos_model, 1'b1);
      expect_ev(3'b001, pos_model);
      drive(1'b0, 1'b0);
      check("t3_pos", {24'd0, pos}, 32'hFF);
      check("t3_pending", exp_q.size(), 32'd0);

      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      check("t4_pos", {24'd0, pos}, 32'hFF);
      check("t4_sub", {28'd0, dut.sub}, 32'd0);
      cw_detent();
      check("t4_after_pos", {24'd0, pos}, 32'd0);

      a = 1'b1; b = 1'b1;
      expect_ev(3'b100, pos_model);
      hold(Q);
      a = 1'b0; b = 1'b0;
      expect_ev(3'b100, pos_model);
      hold(Q);
      check("t5_pos", {24'd0, pos}, 32'd0);
      check("t5_pending", exp_q.size(), 32'd0);

      load_val = 8'd127; load = 1'b1;
      hold(1);
      load = 1'b0;
      pos_model = 8'd127;
      check("t6_load", {24'd0, pos}, 32'd127);
      cw_detent();
`ifdef QENC_SAT_EN
      check("t6_sat_pos", {24'd0, pos}, 32'h7F);
`else
      check("t6_wrap_pos", {24'd0, pos}, 32'h80);
`endif
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      pos_model = 8'd0;
      expect_ev(3'b001, pos_model);
      a = 1'b0; b = 1'b0;
      hold(LAT - 1);
      clr = 1'b1;
      hold(1);
      clr = 1'b0;
      hold(Q - LAT);
      check("t6_clr_pos", {24'd0, pos}, 32'd0);
      check("t6_pending", exp_q.size(), 32'd0);

      load_val = 8'h55; load = 1'b1; clr = 1'b1;
      hold(1);
      check("prio_clr_over_load", {24'd0, pos}, 32'd0);
      clr = 1'b0;
      hold(1);
      load = 1'b0;
      check("load_value", {24'd0, pos}, 32'h55);
      pos_model = 8'h55;

      drive(1'b1, 1'b0);
      a = 1'b1; b = 1'b1; hold(2);
      rst = 1'b1; hold(2);
      pos_model = 8'd0;
      check("t7_reset_pos", {24'd0, pos}, 32'd0);
      rst = 1'b0;
      expect_ev(3'b100, pos_model);
      hold(Q);
      check("t7_pending", exp_q.size(), 32'd0);
      a = 1'b0; b = 1'b0;
      expect_ev(3'b100, pos_model);
      hold(Q);
      cw_detent();
      check("t7_pos", {24'd0, pos}, 32'd1);
      check("final_pending", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_enc_ctrl.md
Name: quad_enc_ctrl

Overview:
Synthesizable front-end controller for a mechanical quadrature encoder, the DUT-side counterpart of the simulated encoder and key-bounce stimulus. It synchronizes and glitch-filters the A/B contacts, then decodes Gray-code phase transitions. It emits one step pulse per full detent cycle (00→00) and maintains a signed position register with clear and load.

Parameters:
FILT_CYC, 16, consecutive stable cycles required before a filtered input changes (≥1)
POS_W, 16, position register width, signed two's complement (≥2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
a  in  1  encoder contact A, asynchronous
b  in  1  encoder contact B, asynchronous
clr  in  1  synchronous position/sub-step clear
load  in  1  synchronous position load
load_val  in  POS_W  value loaded when load=1
pos  out  POS_W  signed position
step_cw  out  1  one-cycle pulse per completed CW detent
step_ccw  out  1  one-cycle pulse per completed CCW detent
err  out  1  one-cycle pulse on illegal two-bit phase jump

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high. While rst=1, all flops clear: sync FFs=0, filtered a/b=0, filter counters=0, phase=0, sub=0, pos=0, step_cw=step_ccw=err=0.
- Sync: two FFs per input.
- Filter:
  - Each input has its own counter that increments while the synced value ≠ the filtered value, and resets to 0 when they are equal.
  - On reaching FILT_CYC, the filtered value takes the synced value and the counter resets.
  - A glitch shorter than FILT_CYC cycles never propagates.
- Phase index from filtered (a,b): 00→0, 10→1, 11→2, 01→3. CW means A leads.
- Decode (registered, one cycle after the filtered change). Let d = (new − old) mod 4:
  - d=1: sub += 1.
  - d=3: sub −= 1.
  - d=2: err pulse; sub unchanged.
  - d=0: nothing.
  - When the new phase is 0: sub=+4 → step_cw; sub=−4 → step_ccw; any other value → no step. sub returns to 0 in all cases.
  - sub is 4-bit signed and bounded to ±4 by construction.
- Partial motion that reverses before reaching 00 cancels and produces no step.
- Latency: an input level change that stays stable produces its step pulse and pos update FILT_CYC+3 clock edges after the first edge that samples the new level (2 sync + FILT_CYC filter + 1 decode).
- Position:
  - Priority is clr > load > step.
  - clr: pos=0 and sub=0.
  - load: pos=load_val; sub unaffected.
  - Otherwise step_cw → pos+1, step_ccw → pos−1.
  - Step pulses are still emitted in a cycle where clr or load overrides them.
  - Default arithmetic wraps modulo 2^POS_W.
- Simultaneous a and b filtered changes in one cycle count as d=2, so err is pulsed.
- Reset mid-detent discards sub. After release, phase restarts from 00. If the contacts rest at 11, both filters settle in the same cycle, giving one err pulse and no step.
- step_cw and step_ccw are never both 1.

Optional Feature:
QENC_SAT_EN
- Defined: pos saturates at the signed max (2^(POS_W−1)−1) on CW and at the signed min (−2^(POS_W−1)) on CCW. Step pulses are still emitted.
- Undefined: pos wraps modulo 2^POS_W.

Decomposition:
- Package QEncPkg:
  - phase_t (2-bit Gray index)
  - sub_t (4-bit signed)
  - constants PH_00=0, PH_10=1, PH_11=2, PH_01=3, SUB_DETENT=4
  - function phase_of(a,b)
- Sub-module glitch_filter (2-FF sync plus stability counter, parameter FILT_CYC), instantiated twice.
- Decode and position logic live in quad_enc_ctrl.

Test Plan:
All scenarios use FILT_CYC=4, POS_W=8, a 100 MHz clock and a 200 ns quarter period.
1. Reset, then 3 CW detents (a leads) → 3 step_cw pulses, pos=3, err never set; each pulse at FILT_CYC+3=7 edges after the final B fall.
2. From pos=3, 5 CCW detents → 5 step_ccw pulses, pos=8'hFE (−2).
3. Bounce on a (0→1 for 2 cycles, back to 0), repeated 30× → no filtered change, no pulses, pos unchanged. A 30-cycle stable high then updates the filtered value.
4. Partial sequence 00→10→11→10→00 → no step, pos unchanged, sub back to 0.
5. a and b driven 0→1 in the same cycle and held → exactly one err pulse; returning both to 0 gives one more err pulse and no step.
6. load=1, load_val=127, then one CW detent → pos=−128 (wrap), or 127 with QENC_SAT_EN. Then clr asserted in the same cycle as a step_cw pulse → pos=0 and step_cw is still pulsed.
